// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM encodings, zero values.
package ex_muldiv_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_END  = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg  = 5'd0;

  function automatic logic is_div_op(input logic [2:0] op);
    return op inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return op inside {INST_REM, INST_REMU};
  endfunction

  function automatic logic op1_signed(input logic [2:0] op);
    return op inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
  endfunction

  function automatic logic op2_signed(input logic [2:0] op);
    return op inside {INST_MULH, INST_DIV, INST_REM};
  endfunction

  function automatic logic is_mul_op(input logic [2:0] op);
    return op inside {INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: restoring divide step or shift-add multiply step.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    diff = acc_i[2*XLEN-1:XLEN-1] - {1'b0, operand_i};
    if (!is_div_i)
      acc_o = {sum, acc_i[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    else
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit in EX; stalls the pipeline while iterating.
// MULDIV_FAST_MUL_EN: single-cycle multiplies through a 33x33 signed product.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]        state_reg;
  logic [2:0]        op_reg;
  logic [4:0]        waddr_reg;
  logic              neg_reg, sign1_reg;
  logic [2*XLEN-1:0] acc_reg, step_acc, prod;
  logic [XLEN-1:0]   operand_reg, result_reg, fix_res, quot, rem;
  logic [CNT_W-1:0]  cnt_reg;

  logic            s1, s2, accept, div_zero, div_ovf;
  logic [XLEN-1:0] abs1, abs2;

  assign s1       = op1_signed(op_i) & op1_i[XLEN-1];
  assign s2       = op2_signed(op_i) & op2_i[XLEN-1];
  assign abs1     = s1 ? -op1_i : op1_i;
  assign abs2     = s2 ? -op2_i : op2_i;
  assign accept   = (state_reg == MD_IDLE) & start_i & ~flush_i;
  assign div_zero = is_div_op(op_i) & (op2_i == '0);
  assign div_ovf  = ((op_i == INST_DIV) | (op_i == INST_REM)) &
                    (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_p;
  logic [XLEN-1:0]          fast_res;

  assign fast_a   = {s1, op1_i};
  assign fast_b   = {s2, op2_i};
  assign fast_p   = fast_a * fast_b;
  assign fast_res = (op_i == INST_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i  (is_div_op(op_reg)),
    .acc_i     (acc_reg),
    .operand_i (operand_reg),
    .acc_o     (step_acc)
  );

  // Sign fix-up on the final iteration's output, written straight into result_reg
  assign prod    = neg_reg ? -step_acc : step_acc;
  assign quot    = neg_reg ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
  assign rem     = sign1_reg ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
  assign fix_res = is_div_op(op_reg) ? (is_rem_op(op_reg) ? rem : quot)
                 : ((op_reg == INST_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= MD_IDLE;
      op_reg      <= INST_MUL;
      waddr_reg   <= ZeroReg;
      neg_reg     <= 1'b0;
      sign1_reg   <= 1'b0;
      acc_reg     <= '0;
      operand_reg <= '0;
      result_reg  <= XLEN'(ZeroWord);
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (accept) begin
            op_reg    <= op_i;
            waddr_reg <= reg_waddr_i;
            sign1_reg <= s1;
            neg_reg   <= s1 ^ s2;
            cnt_reg   <= '0;
            if (div_zero) begin
              result_reg <= is_rem_op(op_i) ? op1_i : '1;
              state_reg  <= MD_END;
            end else if (div_ovf) begin
              result_reg <= is_rem_op(op_i) ? '0 : op1_i;
              state_reg  <= MD_END;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (is_mul_op(op_i)) begin
              result_reg <= fast_res;
              state_reg  <= MD_END;
            end
`endif
            else begin
              acc_reg     <= {{XLEN{1'b0}}, is_div_op(op_i) ? abs1 : abs2};
              operand_reg <= is_div_op(op_i) ? abs2 : abs1;
              state_reg   <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (flush_i) begin
            state_reg <= MD_IDLE;
          end else begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
              result_reg <= fix_res;
              state_reg  <= MD_END;
            end
          end
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_reg == MD_END) & ~flush_i;
  assign reg_we_o    = ready_o;
  assign reg_waddr_o = waddr_reg;
  assign result_o    = result_reg;
  assign busy_o      = (state_reg != MD_IDLE);
  assign stall_o     = accept | ((state_reg == MD_CALC) & ~flush_i);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (divide, multiply, special cases, flush, reset).
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o, reg_we_o, busy_o, stall_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .busy_o      (busy_o),
    .stall_o     (stall_o)
  );

  // Issue one op and wait for completion; lat counts edges from the sampling edge inclusive
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output int stalls, output logic we, output logic [4:0] waddr,
                       output logic ready_after);
    bit done;
    done = 0;
    @(negedge clk);
    op_i = op; op1_i = a; op2_i = b; reg_waddr_i = rd; start_i = 1'b1;
    lat = 0; stalls = 0; res = 'x; we = 1'b0; waddr = 'x; ready_after = 1'bx;
    while (!done && lat < 60) begin
      #1;
      if (stall_o) stalls++;
      @(posedge clk);
      lat++;
      #1;
      start_i = 1'b0;
      if (ready_o) begin
        res = result_o; we = reg_we_o; waddr = reg_waddr_o; done = 1;
      end
    end
    if (done) begin
      @(posedge clk);
      #1 ready_after = ready_o;
    end
    $display("op=%0d a=%h b=%h rd=%0d -> result=%h latency=%0d stall=%0d",
             op, a, b, rd, res, lat, stalls);
  endtask

  task automatic test_reset();
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", reg_we_o); end
    checks++; if (reg_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %h expected 0", reg_waddr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
  endtask

  task automatic test_div_basic();
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    do_op(INST_DIV, 32'd100, 32'd7, 5'd9, res, lat, stalls, we, wa, ra);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL div_100_7: got %h expected %h", res, 32'd14); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
    checks++; if (stalls !== 33) begin errors++; $display("FAIL div_stall_cycles: got %0d expected 33", stalls); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL div_reg_we: got %b expected 1", we); end
    checks++; if (wa !== 5'd9) begin errors++; $display("FAIL div_waddr: got %0d expected 9", wa); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL div_ready_one_cycle: got %b expected 0", ra); end
  endtask

  task automatic test_div_signs();
    logic [2:0]  ops [3] = '{INST_DIV, INST_REM, INST_REMU};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 32'hFFFF_FFF9, 32'd2, 5'd3, res, lat, stalls, we, wa, ra);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL div_sign_%0d: got %h expected %h", i, res, exp[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_sign_lat_%0d: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{INST_DIVU, INST_REMU, INST_DIV, INST_REM};
    logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], av[i], bv[i], 5'd17, res, lat, stalls, we, wa, ra);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL special_%0d: got %h expected %h", i, res, exp[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_lat_%0d: got %0d expected 1", i, lat); end
      checks++; if (we !== 1'b1 || wa !== 5'd17) begin errors++; $display("FAIL special_wb_%0d: got we=%b rd=%0d expected we=1 rd=17", i, we, wa); end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [6] = '{INST_MUL, INST_MULHU, INST_MULH, INST_MULHSU, INST_MUL, INST_MULH};
    logic [31:0] av  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd7};
    logic [31:0] bv  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] exp [6] = '{32'd1, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], av[i], bv[i], 5'd4, res, lat, stalls, we, wa, ra);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL mul_%0d: got %h expected %h", i, res, exp[i]); end
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_lat_%0d: got %0d expected %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_busy_start();
    int first_ready; logic [31:0] res;
    first_ready = 0; res = '0;
    @(negedge clk);
    op_i = INST_DIV; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd2; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int e = 2; e <= 40 && first_ready == 0; e++) begin
      if (e == 6) begin op_i = INST_DIVU; op1_i = 32'd5; op2_i = 32'd0; start_i = 1'b1; end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (ready_o) begin first_ready = e; res = result_o; end
    end
    $display("busy start: first ready after edge %0d result=%h", first_ready, res);
    checks++; if (first_ready !== 33) begin errors++; $display("FAIL busy_start_lat: got %0d expected 33", first_ready); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL busy_start_result: got %h expected %h", res, 32'd14); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int spurious;
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    spurious = 0;
    @(negedge clk);
    op_i = INST_DIV; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd11; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
    checks++; if (ready_o !== 1'b0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b/%b expected 0/0", ready_o, reg_we_o); end
    @(posedge clk); #1 flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy_o); end
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || reg_we_o) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL flush_no_writeback: got %0d strobes expected 0", spurious); end
    do_op(INST_DIV, 32'd77, 32'd11, 5'd12, res, lat, stalls, we, wa, ra);
    checks++; if (res !== 32'd7 || lat !== 33) begin errors++; $display("FAIL flush_restart: got %h lat %0d expected 7 lat 33", res, lat); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat, stalls; logic we, ra; logic [4:0] wa;
    @(negedge clk);
    op_i = INST_DIV; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd21; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL arst_busy_stall: got %b/%b expected 0/0", busy_o, stall_o); end
    checks++; if (result_o !== 32'h0 || reg_waddr_o !== 5'd0) begin errors++; $display("FAIL arst_regs: got %h/%0d expected 0/0", result_o, reg_waddr_o); end
    checks++; if (ready_o !== 1'b0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b/%b expected 0/0", ready_o, reg_we_o); end
    @(negedge clk); rst = 1'b1;
    do_op(INST_DIV, 32'd9, 32'd3, 5'd6, res, lat, stalls, we, wa, ra);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL arst_div_9_3: got %h expected 3", res); end
    checks++; if (lat !== 33 || wa !== 5'd6) begin errors++; $display("FAIL arst_div_lat_rd: got %0d/%0d expected 33/6", lat, wa); end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b1;
    test_div_basic();
    test_div_signs();
    test_special();
    test_mul();
    test_busy_start();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
